cnn_layer_sched: RTL and testbench



---
 rtl/cnn_layer_sched_if.sv | 43 ++++
 rtl/cnn_layer_sched.sv | 120 ++++++++++++
 tb/tb_cnn_layer_sched.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_layer_sched_if.sv
// Frame handshake, per-layer start/busy and status bundle
// for the CIM layer-chain scheduler.
interface cnn_layer_sched_if #(
  parameter int num_layers = 5,
  parameter int cnt_width  = 16
);
  logic                  i_frame_valid;
  logic                  o_frame_ready;
  logic [num_layers-1:0] o_start;
  logic [num_layers-1:0] i_busy;
  logic [num_layers-1:0] o_next_busy;
  logic                  o_out_valid;
  logic                  i_out_ready;
  logic [cnt_width-1:0]  o_frames_done;
  logic [num_layers-1:0] o_error;
  logic                  i_clear_error;

  modport master (
    input  i_frame_valid,
    input  i_busy,
    input  i_out_ready,
    input  i_clear_error,
    output o_frame_ready,
    output o_start,
    output o_next_busy,
    output o_out_valid,
    output o_frames_done,
    output o_error
  );

  modport slave (
    output i_frame_valid,
    output i_busy,
    output i_out_ready,
    output i_clear_error,
    input  o_frame_ready,
    input  o_start,
    input  o_next_busy,
    input  o_out_valid,
    input  o_frames_done,
    input  o_error
  );
endinterface

// File: rtl/cnn_layer_sched.sv
// Frame scheduler for a linear chain of CIM layers: one frame
// slot per layer, start/busy tracking, arm timeout, back-pressure.
module cnn_layer_sched #(
  parameter int num_layers  = 5,
  parameter int arm_timeout = 4,
  parameter int cnt_width   = 16
) (
  input logic               clk,
  input logic               rst,
  cnn_layer_sched_if.master bus
);

  localparam int AW = $clog2(arm_timeout + 1);

  typedef enum logic [2:0] {
    EMPTY,
    START,
    ARM,
    RUN,
    FULL
  } slot_e;

  slot_e                 state_q [num_layers];
  slot_e                 state_d [num_layers];
  logic [AW-1:0]         arm_q   [num_layers];
  logic [AW-1:0]         arm_d   [num_layers];
  logic [num_layers-1:0] take;
  logic [num_layers-1:0] drain;
  logic [num_layers-1:0] err_set;
  logic [num_layers-1:0] err_q;
  logic [cnt_width-1:0]  done_q;
  logic                  out_valid;
  logic                  out_fire;

  assign out_valid = (state_q[num_layers-1] == FULL);
  assign out_fire  = out_valid & bus.i_out_ready;

  // take: slot starts a frame; drain: FULL slot hands its frame on
  always_comb begin
    take  = '0;
    drain = '0;
    take[0] = bus.i_frame_valid & (state_q[0] == EMPTY);
    for (int k = 1; k < num_layers; k++) begin
      take[k] = (state_q[k] == EMPTY)
              & (state_q[k-1] == FULL);
      drain[k-1] = (state_q[k] == EMPTY)
                 & (state_q[k-1] == FULL);
    end
    drain[num_layers-1] = out_fire;
  end

  always_comb begin
    err_set = '0;
    for (int k = 0; k < num_layers; k++) begin
      state_d[k] = state_q[k];
      arm_d[k]   = arm_q[k];
      unique case (state_q[k])
        EMPTY: begin
          if (take[k]) state_d[k] = START;
        end
        START: begin
          state_d[k] = ARM;
          arm_d[k]   = '0;
        end
        ARM: begin
          if (bus.i_busy[k]) begin
            state_d[k] = RUN;
          end else if (arm_q[k] == AW'(arm_timeout - 1)) begin
            err_set[k] = 1'b1;
            state_d[k] = EMPTY;
          end else begin
            arm_d[k] = arm_q[k] + 1'b1;
          end
        end
        RUN: begin
          if (!bus.i_busy[k]) state_d[k] = FULL;
        end
        FULL: begin
          if (drain[k]) state_d[k] = EMPTY;
        end
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < num_layers; k++) begin
        state_q[k] <= EMPTY;
        arm_q[k]   <= '0;
      end
      err_q  <= '0;
      done_q <= '0;
    end else begin
      for (int k = 0; k < num_layers; k++) begin
        state_q[k] <= state_d[k];
        arm_q[k]   <= arm_d[k];
      end
      // a new timeout outranks a clear in the same cycle
      err_q <= (bus.i_clear_error ? '0 : err_q) | err_set;
      if (out_fire) done_q <= done_q + 1'b1;
    end
  end

  always_comb begin
    bus.o_start     = '0;
    bus.o_next_busy = '0;
    for (int k = 0; k < num_layers; k++)
      bus.o_start[k] = (state_q[k] == START);
    for (int k = 0; k < num_layers - 1; k++)
      bus.o_next_busy[k] = (state_q[k+1] != EMPTY);
    bus.o_next_busy[num_layers-1] = out_valid & ~bus.i_out_ready;
  end

  assign bus.o_frame_ready = (state_q[0] == EMPTY);
  assign bus.o_out_valid   = out_valid;
  assign bus.o_frames_done = done_q;
  assign bus.o_error       = err_q;

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Self-checking bench for cnn_layer_sched: behavioural layer
// models with random timing, event counters and latency rules.
module tb_cnn_layer_sched;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cnn_layer_sched_if #(.num_layers(N), .cnt_width(16)) bus ();
  cnn_layer_sched_if #(.num_layers(N), .cnt_width(2))  bus2 ();

  assign bus2.i_frame_valid = bus.i_frame_valid;
  assign bus2.i_busy        = bus.i_busy;
  assign bus2.i_out_ready   = bus.i_out_ready;
  assign bus2.i_clear_error = bus.i_clear_error;

  cnn_layer_sched #(.num_layers(N), .arm_timeout(4), .cnt_width(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );
  cnn_layer_sched #(.num_layers(N), .arm_timeout(4), .cnt_width(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt [N];
  int start_cyc [N];
  int acc_cnt = 0;
  int hs_cnt = 0;
  int hs_base = 0;
  int pend [N];
  int left [N];
  logic [N-1:0] dead = '0;
  logic fixed = 1'b1;
  int dur_max = 4;
  int pend_max = 2;

  // layer model: busy rises pend cycles after start, stays left cycles
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int k = 0; k < N; k++) begin
        if (!rst) begin
          pend[k] = 0;
          left[k] = 0;
          bus.i_busy[k] = 1'b0;
        end else begin
          if (bus.i_busy[k]) begin
            left[k]--;
            if (left[k] <= 0) bus.i_busy[k] = 1'b0;
          end else if (pend[k] > 0) begin
            pend[k]--;
            if (pend[k] == 0) begin
              bus.i_busy[k] = 1'b1;
              left[k] = fixed ? 10 : int'($urandom_range(1, dur_max));
            end
          end
          if (bus.o_start[k] && !dead[k])
            pend[k] = fixed ? 1 : int'($urandom_range(1, pend_max));
        end
      end
    end
  end

  // event counters; values seen here are what the next edge samples
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (bus.o_start[k] === 1'b1) begin
          start_cnt[k]++;
          start_cyc[k] = cyc;
        end
      end
      if (bus.i_frame_valid && bus.o_frame_ready) acc_cnt++;
      if (bus.o_out_valid && bus.i_out_ready) hs_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_frame_valid = 1'b0;
    bus.i_out_ready = 1'b1;
    bus.i_clear_error = 1'b0;
    dead = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    hs_base = hs_cnt;
    tick();
  endtask

  task automatic send_frame(output int t_acc);
    int a0;
    a0 = acc_cnt;
    t_acc = -1;
    bus.i_frame_valid = 1'b1;
    for (int i = 0; i < 60 && t_acc < 0; i++) begin
      tick();
      if (acc_cnt != a0) t_acc = cyc;
    end
    bus.i_frame_valid = 1'b0;
    if (t_acc < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout: no accept within 60 cycles");
    end
  endtask

  task automatic test_reset();
    bus.i_frame_valid = 1'b0;
    bus.i_busy = '0;
    bus.i_out_ready = 1'b0;
    bus.i_clear_error = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    hs_base = hs_cnt;
    tick();
    total++;
    if (bus.o_frame_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", bus.o_frame_ready);
    end
    total++;
    if (bus.o_start !== 5'b0) begin
      bad++; $display("FAIL reset_start: got %b want 0", bus.o_start);
    end
    total++;
    if (bus.o_out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %b want 0", bus.o_out_valid);
    end
    total++;
    if (bus.o_next_busy !== 5'b0) begin
      bad++; $display("FAIL reset_next_busy: got %b want 0", bus.o_next_busy);
    end
    total++;
    if (bus.o_frames_done !== 16'd0) begin
      bad++; $display("FAIL reset_done: got %0d want 0", bus.o_frames_done);
    end
    total++;
    if (bus.o_error !== 5'b0) begin
      bad++; $display("FAIL reset_error: got %b want 0", bus.o_error);
    end
  endtask

  task automatic test_single_frame();
    int s0 [N];
    int t_acc;
    int ov;
    do_reset();
    fixed = 1'b1;
    for (int k = 0; k < N; k++) s0[k] = start_cnt[k];
    send_frame(t_acc);
    ov = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.o_out_valid) ov++;
      tick();
    end
    for (int k = 0; k < N; k++) begin
      total++;
      if (start_cnt[k] - s0[k] != 1) begin
        bad++;
        $display("FAIL single_start_cnt[%0d]: got %0d want 1", k, start_cnt[k] - s0[k]);
      end
      total++;
      if (start_cyc[k] != t_acc + 13 * k) begin
        bad++;
        $display("FAIL single_start_cyc[%0d]: got %0d want %0d", k, start_cyc[k], t_acc + 13 * k);
      end
    end
    total++;
    if (ov != 1) begin
      bad++; $display("FAIL single_out_valid_width: got %0d want 1", ov);
    end
    total++;
    if (bus.o_frames_done !== 16'd1) begin
      bad++; $display("FAIL single_done: got %0d want 1", bus.o_frames_done);
    end
  endtask

  task automatic test_back_to_back();
    int s0 [N];
    int a0, rise_bad, low_bad, i;
    logic prev_rdy;
    do_reset();
    fixed = 1'b0;
    dur_max = 6;
    pend_max = 3;
    for (int k = 0; k < N; k++) s0[k] = start_cnt[k];
    a0 = acc_cnt;
    rise_bad = 0;
    low_bad = -1;
    prev_rdy = 1'b1;
    bus.i_frame_valid = 1'b1;
    for (i = 0; i < 600 && (hs_cnt - hs_base) < 3; i++) begin
      tick();
      if (acc_cnt - a0 == 1 && low_bad < 0)
        low_bad = (bus.o_frame_ready !== 1'b0) ? 1 : 0;
      if (acc_cnt - a0 >= 3) bus.i_frame_valid = 1'b0;
      if (bus.o_frame_ready && !prev_rdy && !bus.o_start[1]) rise_bad++;
      prev_rdy = bus.o_frame_ready;
    end
    bus.i_frame_valid = 1'b0;
    total++;
    if (low_bad != 0) begin
      bad++; $display("FAIL b2b_ready_drop: got %0d want 0", low_bad);
    end
    total++;
    if (rise_bad != 0) begin
      bad++; $display("FAIL b2b_ready_rise_handover: got %0d bad rises want 0", rise_bad);
    end
    total++;
    if (bus.o_frames_done !== 16'd3) begin
      bad++; $display("FAIL b2b_done: got %0d want 3", bus.o_frames_done);
    end
    for (int k = 0; k < N; k++) begin
      total++;
      if (start_cnt[k] - s0[k] != 3) begin
        bad++;
        $display("FAIL b2b_start_cnt[%0d]: got %0d want 3", k, start_cnt[k] - s0[k]);
      end
    end
  endtask

  task automatic test_stall();
    int a0, nb_bad, ov_seen, step_bad, acc_n;
    do_reset();
    fixed = 1'b0;
    dur_max = 3;
    pend_max = 1;
    a0 = acc_cnt;
    nb_bad = 0;
    ov_seen = 0;
    bus.i_out_ready = 1'b0;
    bus.i_frame_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.o_out_valid) begin
        ov_seen++;
        if (bus.o_next_busy[N-1] !== 1'b1) nb_bad++;
      end
    end
    total++;
    if (ov_seen == 0 || nb_bad != 0) begin
      bad++; $display("FAIL stall_next_busy4: valid_cycles=%0d low_cycles=%0d", ov_seen, nb_bad);
    end
    total++;
    if (bus.o_next_busy !== 5'b11111) begin
      bad++; $display("FAIL stall_fill: got %b want 11111", bus.o_next_busy);
    end
    total++;
    if (bus.o_frame_ready !== 1'b0) begin
      bad++; $display("FAIL stall_ready: got %b want 0", bus.o_frame_ready);
    end
    total++;
    if (bus.o_frames_done !== 16'd0) begin
      bad++; $display("FAIL stall_done: got %0d want 0", bus.o_frames_done);
    end
    acc_n = acc_cnt - a0;
    bus.i_frame_valid = 1'b0;
    bus.i_out_ready = 1'b1;
    step_bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.o_frames_done !== 16'(hs_cnt - hs_base)) step_bad++;
    end
    total++;
    if (step_bad != 0) begin
      bad++; $display("FAIL stall_drain_steps: got %0d bad cycles want 0", step_bad);
    end
    total++;
    if (acc_n != 5 || bus.o_frames_done !== 16'd5) begin
      bad++; $display("FAIL stall_drain_total: accepted=%0d done=%0d want 5", acc_n, bus.o_frames_done);
    end
  endtask

  task automatic test_dead_layer();
    int t_acc, s2, s3, sc;
    do_reset();
    fixed = 1'b1;
    dead = 5'b00100;
    s2 = start_cnt[2];
    s3 = start_cnt[3];
    send_frame(t_acc);
    for (int i = 0; i < 80 && start_cnt[2] == s2; i++) tick();
    total++;
    if (start_cnt[2] == s2) begin
      bad++; $display("FAIL dead_start2: got no start want one");
    end else begin
      sc = start_cyc[2];
      while (cyc < sc + 4) tick();
      total++;
      if (bus.o_error !== 5'b0 || bus.o_next_busy[1] !== 1'b1) begin
        bad++; $display("FAIL dead_arm_window: err=%b nb1=%b want 00000/1", bus.o_error, bus.o_next_busy[1]);
      end
      tick();
      total++;
      if (bus.o_error !== 5'b00100) begin
        bad++; $display("FAIL dead_error: got %b want 00100", bus.o_error);
      end
      total++;
      if (bus.o_next_busy[1] !== 1'b0) begin
        bad++; $display("FAIL dead_slot2_empty: got %b want 0", bus.o_next_busy[1]);
      end
    end
    repeat (30) tick();
    total++;
    if (start_cnt[3] != s3) begin
      bad++; $display("FAIL dead_start3: got %0d starts want 0", start_cnt[3] - s3);
    end
    total++;
    if (bus.o_error !== 5'b00100) begin
      bad++; $display("FAIL dead_sticky: got %b want 00100", bus.o_error);
    end
    bus.i_clear_error = 1'b1;
    tick();
    bus.i_clear_error = 1'b0;
    total++;
    if (bus.o_error !== 5'b0) begin
      bad++; $display("FAIL dead_clear: got %b want 0", bus.o_error);
    end
    dead = '0;
  endtask

  task automatic test_reset_midflight();
    int a0, s0 [N];
    do_reset();
    fixed = 1'b0;
    dur_max = 5;
    pend_max = 2;
    a0 = acc_cnt;
    bus.i_frame_valid = 1'b1;
    for (int i = 0; i < 300 && acc_cnt - a0 < 3; i++) tick();
    bus.i_frame_valid = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (bus.o_frame_ready !== 1'b1 || bus.o_start !== 5'b0 || bus.o_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_outputs: ready=%b start=%b ov=%b want 1/0/0",
               bus.o_frame_ready, bus.o_start, bus.o_out_valid);
    end
    total++;
    if (bus.o_next_busy !== 5'b0 || bus.o_error !== 5'b0 || bus.o_frames_done !== 16'd0) begin
      bad++;
      $display("FAIL midrst_state: nb=%b err=%b done=%0d want 0",
               bus.o_next_busy, bus.o_error, bus.o_frames_done);
    end
    tick();
    tick();
    rst = 1'b1;
    hs_base = hs_cnt;
    tick();
    for (int k = 0; k < N; k++) s0[k] = start_cnt[k];
    bus.i_frame_valid = 1'b1;
    for (int i = 0; i < 20 && acc_cnt - a0 < 4; i++) tick();
    bus.i_frame_valid = 1'b0;
    for (int i = 0; i < 200 && hs_cnt == hs_base; i++) tick();
    repeat (2) tick();
    total++;
    if (bus.o_frames_done !== 16'd1) begin
      bad++; $display("FAIL midrst_new_frame: got %0d want 1", bus.o_frames_done);
    end
    for (int k = 0; k < N; k++) begin
      total++;
      if (start_cnt[k] - s0[k] != 1) begin
        bad++;
        $display("FAIL midrst_start_cnt[%0d]: got %0d want 1", k, start_cnt[k] - s0[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] seq [5];
    logic [1:0] want [5];
    int a0, prev_hs, n;
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3;
    want[3] = 2'd0; want[4] = 2'd1;
    do_reset();
    fixed = 1'b0;
    dur_max = 4;
    pend_max = 2;
    a0 = acc_cnt;
    prev_hs = hs_cnt;
    n = 0;
    for (int k = 0; k < 5; k++) seq[k] = 2'bxx;
    bus.i_frame_valid = 1'b1;
    for (int i = 0; i < 800 && n < 5; i++) begin
      tick();
      if (acc_cnt - a0 >= 5) bus.i_frame_valid = 1'b0;
      if (hs_cnt != prev_hs) begin
        seq[n] = bus2.o_frames_done;
        n++;
      end
      prev_hs = hs_cnt;
    end
    bus.i_frame_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (seq[k] !== want[k]) begin
        bad++; $display("FAIL wrap_seq[%0d]: got %0d want %0d", k, seq[k], want[k]);
      end
    end
    total++;
    if (bus.o_frames_done !== 16'd5) begin
      bad++; $display("FAIL wrap_wide_done: got %0d want 5", bus.o_frames_done);
    end
  endtask

  initial begin
    bus.i_frame_valid = 1'b0;
    bus.i_busy = '0;
    bus.i_out_ready = 1'b0;
    bus.i_clear_error = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_dead_layer();
    test_reset_midflight();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
